// File: rtl/wash_phase_timer.sv
// wash_phase_timer
//   Times one washing-machine phase. On an accepted start the phase duration
//   is looked up from the clock-frequency setting, loaded into a down-counter
//   and counted to zero; a one-cycle done marks completion. Spin phases may
//   be held by pause; any active phase can be cancelled by abort.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clk_freq   00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz (sampled on accepted start)
//   phase      00=fill, 01=wash, 10=rinse, 11=spin (sampled on accepted start)
//   start      request to time one phase
//   pause      level, honoured only while timing spin
//   abort      level, cancels the active phase
//   busy       phase being timed (RUN or PAUSED)
//   paused     state is PAUSED
//   done       one-cycle pulse on phase completion
//   start_err  one-cycle pulse after a start rejected while busy
//   cur_phase  latched phase code
//   remaining  cycles left in the active phase
module wash_phase_timer #(
    parameter int CNT_W     = 32,
    parameter int DUR_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       clk_freq,
    input  logic [1:0]       phase,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             start_err,
    output logic [1:0]       cur_phase,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] PH_SPIN = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    // Phase duration in cycles: 1 MHz base value scaled by the frequency
    // setting, then shortened by DUR_SHIFT. A zero result is clamped to one
    // cycle so every accepted start still produces a done.
    function automatic logic [CNT_W-1:0] load_dur(input logic [1:0] ph,
                                                  input logic [1:0] fr);
        logic [31:0] base;
        logic [31:0] scaled;
        case (ph)
            2'b00:   base = 32'h0727_0E00;  // fill, 2 min
            2'b01:   base = 32'h11E1_A300;  // wash, 5 min
            2'b10:   base = 32'h0727_0E00;  // rinse, 2 min
            default: base = 32'h0393_8700;  // spin, 1 min
        endcase
        scaled = (base << fr) >> DUR_SHIFT;
        if (scaled == 32'd0) begin
            scaled = 32'd1;
        end
        return CNT_W'(scaled);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 2'b00;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // The frequency setting only matters while computing the load value, so
    // it is folded into the loaded count rather than kept as separate state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    phase_d = phase;
                    rem_d   = load_dur(phase, clk_freq);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN, S_PAUSED: begin
                err_d = start;
                if (abort) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else if (pause && (phase_q == PH_SPIN)) begin
                    // Pause beats the final decrement, so remaining can sit at 1.
                    state_d = S_PAUSED;
                end else begin
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_d == '0) ? S_DONE : S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign paused    = (state_q == S_PAUSED);
    assign done      = (state_q == S_DONE);
    assign start_err = err_q;
    assign cur_phase = phase_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
module tb_wash_phase_timer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  clk_freq;
    logic [1:0]  phase;
    logic        start;
    logic        start_c;
    logic        pause;
    logic        abort;

    logic        busy, paused, done, start_err;
    logic [1:0]  cur_phase;
    logic [31:0] remaining;

    logic        busy_c, paused_c, done_c, start_err_c;
    logic [1:0]  cur_phase_c;
    logic [31:0] remaining_c;

    int total = 0;
    int bad   = 0;
    int seen_done;

    wash_phase_timer #(.CNT_W(32), .DUR_SHIFT(20)) dut (
        .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .phase(phase),
        .start(start), .pause(pause), .abort(abort),
        .busy(busy), .paused(paused), .done(done), .start_err(start_err),
        .cur_phase(cur_phase), .remaining(remaining)
    );

    wash_phase_timer #(.CNT_W(32), .DUR_SHIFT(31)) dut_c (
        .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .phase(phase),
        .start(start_c), .pause(pause), .abort(abort),
        .busy(busy_c), .paused(paused_c), .done(done_c), .start_err(start_err_c),
        .cur_phase(cur_phase_c), .remaining(remaining_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; returns at the following falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clk_freq = 2'b00; phase = 2'b00;
        start = 1'b0; start_c = 1'b0; pause = 1'b0; abort = 1'b0;

        // Reset state
        step(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rem", remaining, 32'd0);
        chk("rst_phase", {30'd0, cur_phase}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Fill nominal, D=114
        clk_freq = 2'b00; phase = 2'b00; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("fill_load_rem", remaining, 32'd114);
        chk("fill_load_busy", {31'd0, busy}, 32'd1);
        step(113);
        chk("fill_e113_rem", remaining, 32'd1);
        chk("fill_e113_done", {31'd0, done}, 32'd0);
        step(1);
        chk("fill_e114_done", {31'd0, done}, 32'd1);
        chk("fill_e114_busy", {31'd0, busy}, 32'd0);
        step(1);
        chk("fill_e115_done", {31'd0, done}, 32'd0);

        // Spin with 10 paused edges, D=114, done after E124
        clk_freq = 2'b01; phase = 2'b11; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("spin_load_rem", remaining, 32'd114);
        step(20);
        chk("spin_e20_rem", remaining, 32'd94);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("spin_paused", {31'd0, paused}, 32'd1);
            chk("spin_frozen", remaining, 32'd94);
        end
        pause = 1'b0;
        step(1);
        chk("spin_resume_paused", {31'd0, paused}, 32'd0);
        chk("spin_resume_rem", remaining, 32'd93);
        step(92);
        chk("spin_e123_rem", remaining, 32'd1);
        chk("spin_e123_done", {31'd0, done}, 32'd0);
        step(1);
        chk("spin_e124_done", {31'd0, done}, 32'd1);
        step(1);

        // Wash ignores pause, D=286
        clk_freq = 2'b00; phase = 2'b01; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("wash_load_rem", remaining, 32'd286);
        step(20);
        pause = 1'b1;
        step(10);
        chk("wash_pause_ign_paused", {31'd0, paused}, 32'd0);
        chk("wash_pause_ign_rem", remaining, 32'd256);
        pause = 1'b0;
        step(255);
        chk("wash_e285_done", {31'd0, done}, 32'd0);
        step(1);
        chk("wash_e286_done", {31'd0, done}, 32'd1);

        // Start in DONE cycle: rinse reload, no idle bubble
        clk_freq = 2'b00; phase = 2'b10; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("b2b_rem", remaining, 32'd114);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done", {31'd0, done}, 32'd0);
        chk("b2b_phase", {30'd0, cur_phase}, 32'd2);

        // Start while running is rejected
        step(5);
        chk("rej_pre_rem", remaining, 32'd109);
        clk_freq = 2'b11; phase = 2'b11; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("rej_err", {31'd0, start_err}, 32'd1);
        chk("rej_rem", remaining, 32'd108);
        chk("rej_phase", {30'd0, cur_phase}, 32'd2);
        step(1);
        chk("rej_err_drop", {31'd0, start_err}, 32'd0);
        chk("rej_rem2", remaining, 32'd107);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_rinse_busy", {31'd0, busy}, 32'd0);

        // Pause on the final decrement edge: pause wins
        clk_freq = 2'b01; phase = 2'b11; start = 1'b1;
        step(1);
        start = 1'b0;
        step(113);
        chk("last_pre_rem", remaining, 32'd1);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("last_pause_rem", remaining, 32'd1);
        chk("last_pause_done", {31'd0, done}, 32'd0);
        step(1);
        chk("last_done", {31'd0, done}, 32'd1);
        step(1);

        // Abort together with pause mid-spin
        clk_freq = 2'b01; phase = 2'b11; start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        chk("abort_pre_rem", remaining, 32'd104);
        abort = 1'b1; pause = 1'b1;
        step(1);
        abort = 1'b0; pause = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_paused", {31'd0, paused}, 32'd0);
        chk("abort_rem", remaining, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 130; i++) begin
            step(1);
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 32'd0);

        // Start after abort works; then reset mid-run at remaining=50
        clk_freq = 2'b00; phase = 2'b00; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("post_abort_rem", remaining, 32'd114);
        chk("post_abort_phase", {30'd0, cur_phase}, 32'd0);
        step(64);
        chk("mid_rem", remaining, 32'd50);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rem", remaining, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        step(1);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (done || busy) seen_done++;
        end
        chk("arst_no_done", seen_done, 32'd0);

        // Clamp: DUR_SHIFT=31 fill at 1 MHz gives D=1
        clk_freq = 2'b00; phase = 2'b00; start_c = 1'b1;
        step(1);
        start_c = 1'b0;
        chk("clamp_rem", remaining_c, 32'd1);
        chk("clamp_busy", {31'd0, busy_c}, 32'd1);
        step(1);
        chk("clamp_done", {31'd0, done_c}, 32'd1);
        chk("clamp_busy_low", {31'd0, busy_c}, 32'd0);
        step(1);
        chk("clamp_done_drop", {31'd0, done_c}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Programmable phase-duration timer for the washing machine controller. The top-level FSM issues a `start` with a phase code. The block looks up that phase's cycle count from the `clk_freq` setting, counts it down, and returns a single-cycle `done`. The block owns all duration arithmetic, the spin-only pause policy and the abort path, so the sequencing FSM stays free of 32-bit counters.

## Interface
Parameters:
- `CNT_W`, 32: counter/duration width.
- `DUR_SHIFT`, 0: table durations are right-shifted by this amount before loading. Production uses 0; benches use it to shorten runs.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_freq`  in  2  00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz; sampled only on an accepted start.
- `phase`  in  2  00=fill, 01=wash, 10=rinse, 11=spin; sampled only on an accepted start.
- `start`  in  1  request to time one phase.
- `pause`  in  1  level; honoured only while timing spin.
- `abort`  in  1  level; cancels the active phase.
- `busy`  out  1  phase being timed (RUN or PAUSED).
- `paused`  out  1  state is PAUSED.
- `done`  out  1  one-cycle pulse on phase completion.
- `start_err`  out  1  one-cycle pulse when a start is rejected.
- `cur_phase`  out  2  latched phase code.
- `remaining`  out  CNT_W  cycles left.

## Operation
- Duration table, in cycles at 1 MHz (row 00): fill 0x07270E00 (2 min), wash 0x11E1A300 (5 min), rinse 0x07270E00, spin 0x03938700 (1 min).
- Rows 01/10/11 are row 00 shifted left by 1/2/3. Row 11: fill 0x39387000, wash 0x8F0D1800, rinse 0x39387000, spin 0x1C9C3800. All values fit in 32 bits with no overflow.
- Loaded duration D = table >> DUR_SHIFT. If the result is 0, D is clamped to 1.
- States: IDLE, RUN, PAUSED, DONE.
- IDLE or DONE with `start`=1 → RUN; `remaining`=D; `clk_freq` and `phase` are latched.
- RUN/PAUSED: the following priority applies at each edge.
  - `abort` → IDLE; `remaining`=0; no `done`.
  - else `pause` && latched phase==spin → PAUSED; `remaining` holds.
  - else decrement. If the result is 0 → DONE, otherwise → RUN.
- `pause` during fill/wash/rinse is ignored; counting continues.
- DONE with no `start` → IDLE at the next edge.
- `start` while RUN/PAUSED → ignored. `start_err`=1 for one cycle; the count, latched phase and latched freq are unchanged.
- `abort` in IDLE/DONE → no effect.
- `busy`=1 in RUN/PAUSED. `done`=1 only in DONE. `paused`=1 only in PAUSED.

## Timing
- Reset: state IDLE. All outputs (`busy`, `paused`, `done`, `start_err`, `cur_phase`, `remaining`) are 0 immediately on `rst_n` low and stay 0 until the first edge after release.
- Reset mid-phase: the phase is lost and no `done` is issued.
- `start` sampled at edge E0 → `busy`=1 and `remaining`=D after E0.
- With no pause, `remaining` reaches 0 at edge E_D. `done`=1 and `busy`=0 in the cycle after E_D. Phase latency is D cycles, edge to edge.
- Each sampled paused cycle (spin only) extends the phase by exactly one cycle.
- `pause` and the final decrement on the same edge → pause wins; `remaining` stays 1.
- `start` during DONE → reload at that edge. `done` drops, `busy` rises, and there is no idle bubble (back-to-back phases).
- `start_err` is registered. It is high in the cycle after the rejected start edge.
- All outputs are registered. There are no combinational input→output paths.

## Test plan
All scenarios use DUR_SHIFT=20.
- Fill, nominal: `clk_freq`=00, `phase`=00, start at E0 → `remaining`=114, `busy`=1. `done` is high exactly in the cycle after E114, with `busy`=0 in that cycle. `done` is low again after E115.
- Spin with pause: `clk_freq`=01, `phase`=11 (D=114), `pause` high for 10 edges mid-phase → `paused`=1 for 10 cycles, `remaining` frozen, `done` after E124. Repeat with `phase`=01, `clk_freq`=00 (D=286) → pause is ignored and `done` comes after E286.
- Start handling: start during RUN → `start_err` pulses once and `remaining` keeps counting. Start asserted in the DONE cycle with `phase`=10, `clk_freq`=00 → `remaining`=114 on the next cycle, `busy`=1, `done`=0.
- Abort: `abort`=1 together with `pause`=1 mid-spin → IDLE, `remaining`=0, no `done` ever. A subsequent start works normally.
- Reset mid-run: drop `rst_n` asynchronously between edges while `remaining`=50 → all outputs 0 without waiting for a clock edge. After release, no `done` appears.
- Clamp (DUR_SHIFT=31): fill at `clk_freq`=00 gives 0 before clamping, so D=1 → `done` is high in the cycle after E1.
